// File: rtl/multicycle_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : multicycle_sequencer                                        |
// | Description : Multi-cycle main controller for a MIPS-style datapath.     |
// |               Latches the instruction word, decodes opcode/funct and     |
// |               sequences fetch, decode, execute, memory and writeback.    |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module multicycle_sequencer #(
    parameter int MUL_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instruction_memory,
    input  logic        instr_valid,
    input  logic        mem_ready,
    input  logic        alu_zero,
    output logic        pc_write,
    output logic        pc_src,
    output logic        ir_write,
    output logic        reg_write,
    output logic        reg_dst,
    output logic        mem_to_reg,
    output logic        alu_src,
    output logic [2:0]  alu_op,
    output logic        mem_read,
    output logic        mem_write,
    output logic        instr_done,
    output logic        illegal_instr,
    output logic        busy,
    output logic [15:0] instr_count
);

    localparam logic [3:0] c_FETCH  = 4'd0;
    localparam logic [3:0] c_DECODE = 4'd1;
    localparam logic [3:0] c_EXEC   = 4'd2;
    localparam logic [3:0] c_MULW   = 4'd3;
    localparam logic [3:0] c_ADDR   = 4'd4;
    localparam logic [3:0] c_MEM    = 4'd5;
    localparam logic [3:0] c_WB     = 4'd6;
    localparam logic [3:0] c_BRANCH = 4'd7;

    localparam logic [5:0] c_OP_RTYPE = 6'b000001;
    localparam logic [5:0] c_OP_LW    = 6'b000010;
    localparam logic [5:0] c_OP_SW    = 6'b000011;
    localparam logic [5:0] c_OP_BEQ   = 6'b000100;

    localparam logic [5:0] c_FN_ADD = 6'b100000;
    localparam logic [5:0] c_FN_SUB = 6'b100010;
    localparam logic [5:0] c_FN_AND = 6'b100100;
    localparam logic [5:0] c_FN_OR  = 6'b100101;
    localparam logic [5:0] c_FN_MUL = 6'b110010;

    localparam logic [2:0] c_ALU_ADD = 3'b000;
    localparam logic [2:0] c_ALU_SUB = 3'b001;
    localparam logic [2:0] c_ALU_AND = 3'b010;
    localparam logic [2:0] c_ALU_OR  = 3'b011;
    localparam logic [2:0] c_ALU_MUL = 3'b100;

    localparam logic [3:0] c_MUL_LOAD = 4'(MUL_CYCLES - 1);

    logic [3:0]  r_state;
    logic [3:0]  w_next_state;
    logic [31:0] r_ir;
    logic [3:0]  r_mul_cnt;
    logic [15:0] r_instr_count;
    logic        w_mul_load;

    logic [5:0]  w_opcode;
    logic [5:0]  w_funct;
    logic        w_is_alu;
    logic        w_is_mul;
    logic        w_is_lw;
    logic        w_is_sw;
    logic        w_is_beq;
    logic [2:0]  w_rtype_op;
    logic        w_unused_ir;

    assign w_opcode    = r_ir[31:26];
    assign w_funct     = r_ir[5:0];
    assign w_unused_ir = ^r_ir[25:6];

    // Instruction class decode from the latched IR
    always_comb begin
        w_is_alu   = 1'b0;
        w_is_mul   = 1'b0;
        w_rtype_op = c_ALU_ADD;
        if (w_opcode == c_OP_RTYPE) begin
            case (w_funct)
                c_FN_ADD: begin w_is_alu = 1'b1; w_rtype_op = c_ALU_ADD; end
                c_FN_SUB: begin w_is_alu = 1'b1; w_rtype_op = c_ALU_SUB; end
                c_FN_AND: begin w_is_alu = 1'b1; w_rtype_op = c_ALU_AND; end
                c_FN_OR:  begin w_is_alu = 1'b1; w_rtype_op = c_ALU_OR;  end
                c_FN_MUL: w_is_mul = 1'b1;
                default:  ;
            endcase
        end
    end

    assign w_is_lw  = (w_opcode == c_OP_LW);
    assign w_is_sw  = (w_opcode == c_OP_SW);
    assign w_is_beq = (w_opcode == c_OP_BEQ);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= c_FETCH;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state  = r_state;
        w_mul_load    = 1'b0;
        pc_write      = 1'b0;
        pc_src        = 1'b0;
        ir_write      = 1'b0;
        reg_write     = 1'b0;
        reg_dst       = 1'b0;
        mem_to_reg    = 1'b0;
        alu_src       = 1'b0;
        alu_op        = c_ALU_ADD;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        instr_done    = 1'b0;
        illegal_instr = 1'b0;
        case (r_state)
            c_FETCH: begin
                if (instr_valid) begin
                    ir_write     = 1'b1;
                    pc_write     = 1'b1;
                    w_next_state = c_DECODE;
                end
            end
            c_DECODE: begin
                if (w_is_alu) begin
                    w_next_state = c_EXEC;
                end else if (w_is_mul) begin
                    w_mul_load   = 1'b1;
                    w_next_state = c_MULW;
                end else if (w_is_lw || w_is_sw) begin
                    w_next_state = c_ADDR;
                end else if (w_is_beq) begin
                    w_next_state = c_BRANCH;
                end else begin
                    illegal_instr = 1'b1;
                    w_next_state  = c_FETCH;
                end
            end
            c_EXEC: begin
                alu_op       = w_rtype_op;
                w_next_state = c_WB;
            end
            c_MULW: begin
                alu_op = c_ALU_MUL;
                if (r_mul_cnt == 4'd0) begin
                    w_next_state = c_WB;
                end
            end
            c_ADDR: begin
                alu_src      = 1'b1;
                w_next_state = c_MEM;
            end
            c_MEM: begin
                // Strobe is held through the cycle that sees mem_ready
                alu_src   = 1'b1;
                mem_read  = w_is_lw;
                mem_write = w_is_sw;
                if (mem_ready) begin
                    if (w_is_lw) begin
                        w_next_state = c_WB;
                    end else begin
                        instr_done   = 1'b1;
                        w_next_state = c_FETCH;
                    end
                end
            end
            c_WB: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
                if (w_is_lw) begin
                    mem_to_reg = 1'b1;
                end else begin
                    reg_dst = 1'b1;
                    alu_op  = w_is_mul ? c_ALU_MUL : w_rtype_op;
                end
                w_next_state = c_FETCH;
            end
            c_BRANCH: begin
                alu_op       = c_ALU_SUB;
                instr_done   = 1'b1;
                pc_write     = alu_zero;
                pc_src       = alu_zero;
                w_next_state = c_FETCH;
            end
            default: w_next_state = c_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ir <= 32'd0;
        end else if (ir_write) begin
            r_ir <= instruction_memory;
        end
    end

    // Counter starts at MUL_CYCLES-1 so the MULW dwell is exactly MUL_CYCLES
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_mul_cnt <= 4'd0;
        end else if (w_mul_load) begin
            r_mul_cnt <= c_MUL_LOAD;
        end else if (r_state == c_MULW && r_mul_cnt != 4'd0) begin
            r_mul_cnt <= r_mul_cnt - 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_instr_count <= 16'd0;
        end else if (instr_done) begin
            r_instr_count <= r_instr_count + 16'd1;
        end
    end

    assign busy        = (r_state != c_FETCH);
    assign instr_count = r_instr_count;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_multicycle_sequencer                                     |
// | Description : Scoreboard bench for multicycle_sequencer.                 |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_multicycle_sequencer;

    localparam int c_MUL = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] instruction_memory = 32'd0;
    logic        instr_valid = 1'b0;
    logic        instr_valid1 = 1'b0;
    logic        mem_ready = 1'b0;
    logic        alu_zero = 1'b0;

    logic        pc_write, pc_src, ir_write, reg_write, reg_dst, mem_to_reg, alu_src;
    logic [2:0]  alu_op;
    logic        mem_read, mem_write, instr_done, illegal_instr, busy;
    logic [15:0] instr_count;

    logic        d1_pc_write, d1_pc_src, d1_ir_write, d1_reg_write, d1_reg_dst;
    logic        d1_mem_to_reg, d1_alu_src, d1_mem_read, d1_mem_write;
    logic        d1_instr_done, d1_illegal_instr, d1_busy;
    logic [2:0]  d1_alu_op;
    logic [15:0] d1_instr_count;

    always #5 clk = ~clk;

    multicycle_sequencer #(.MUL_CYCLES(c_MUL)) dut (
        .clk(clk), .rst_n(rst_n), .instruction_memory(instruction_memory),
        .instr_valid(instr_valid), .mem_ready(mem_ready), .alu_zero(alu_zero),
        .pc_write(pc_write), .pc_src(pc_src), .ir_write(ir_write),
        .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
        .alu_src(alu_src), .alu_op(alu_op), .mem_read(mem_read),
        .mem_write(mem_write), .instr_done(instr_done),
        .illegal_instr(illegal_instr), .busy(busy), .instr_count(instr_count)
    );

    multicycle_sequencer #(.MUL_CYCLES(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .instruction_memory(instruction_memory),
        .instr_valid(instr_valid1), .mem_ready(mem_ready), .alu_zero(alu_zero),
        .pc_write(d1_pc_write), .pc_src(d1_pc_src), .ir_write(d1_ir_write),
        .reg_write(d1_reg_write), .reg_dst(d1_reg_dst), .mem_to_reg(d1_mem_to_reg),
        .alu_src(d1_alu_src), .alu_op(d1_alu_op), .mem_read(d1_mem_read),
        .mem_write(d1_mem_write), .instr_done(d1_instr_done),
        .illegal_instr(d1_illegal_instr), .busy(d1_busy), .instr_count(d1_instr_count)
    );

    logic [13:0] w_outs;
    assign w_outs = {pc_write, pc_src, ir_write, reg_write, reg_dst, mem_to_reg,
                     alu_src, alu_op, mem_read, mem_write, instr_done, illegal_instr};

    typedef struct {
        int          lat;
        int          ill_cyc;
        bit          regw;
        int          memcyc;
        int          mulcyc;
        logic [2:0]  alu;
        bit          dst;
        bit          m2r;
        bit          pcw;
        bit          rdy;
        logic [15:0] cnt;
    } exp_t;

    exp_t        r_sb[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [15:0] r_model_cnt = 16'd0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference decode: expectations derived from the instruction encoding
    function automatic exp_t model(input logic [31:0] instr, input int waits, input bit zero);
        exp_t       e;
        logic [5:0] op;
        logic [5:0] fn;
        op = instr[31:26];
        fn = instr[5:0];
        e = '{lat: 0, ill_cyc: 0, regw: 0, memcyc: 0, mulcyc: 0, alu: 3'd0,
              dst: 0, m2r: 0, pcw: 0, rdy: 0, cnt: r_model_cnt};
        if (op == 6'b000001 && (fn == 6'b100000 || fn == 6'b100010 ||
                                fn == 6'b100100 || fn == 6'b100101)) begin
            e.lat = 4; e.regw = 1; e.dst = 1;
            e.alu = (fn == 6'b100000) ? 3'd0 : (fn == 6'b100010) ? 3'd1 :
                    (fn == 6'b100100) ? 3'd2 : 3'd3;
        end else if (op == 6'b000001 && fn == 6'b110010) begin
            e.lat = 3 + c_MUL; e.regw = 1; e.dst = 1; e.alu = 3'd4; e.mulcyc = c_MUL + 1;
        end else if (op == 6'b000010) begin
            e.lat = 5 + waits; e.regw = 1; e.m2r = 1; e.memcyc = waits + 1;
        end else if (op == 6'b000011) begin
            e.lat = 4 + waits; e.memcyc = waits + 1; e.rdy = 1;
        end else if (op == 6'b000100) begin
            e.lat = 3; e.alu = 3'd1; e.pcw = zero;
        end else begin
            e.ill_cyc = 2;
        end
        if (e.lat != 0) e.cnt = r_model_cnt + 16'd1;
        return e;
    endfunction

    task automatic exec_instr(input logic [31:0] instr, input int waits, input bit zero,
                              input string tag);
        exp_t e;
        exp_t o;
        int   cyc;
        bit   fin;
        e = model(instr, waits, zero);
        r_sb.push_back(e);
        r_model_cnt = e.cnt;
        o = '{lat: 0, ill_cyc: 0, regw: 0, memcyc: 0, mulcyc: 0, alu: 3'd0,
              dst: 0, m2r: 0, pcw: 0, rdy: 0, cnt: 16'd0};
        @(negedge clk);
        instruction_memory = instr;
        instr_valid = 1'b1;
        mem_ready = 1'b0;
        alu_zero = zero;
        #1;
        check({tag, ".fetch_ir"}, {31'd0, ir_write}, 32'd1);
        check({tag, ".fetch_pc"}, {30'd0, pc_write, pc_src}, 32'd2);
        cyc = 1;
        fin = 1'b0;
        while (!fin && cyc < 40) begin
            @(posedge clk);
            @(negedge clk);
            cyc++;
            instr_valid = 1'b0;
            mem_ready = 1'b0;
            #1;
            if (mem_read || mem_write) begin
                o.memcyc++;
                if (o.memcyc > waits) begin
                    mem_ready = 1'b1;
                    #1;
                end
            end
            if (reg_write) o.regw = 1'b1;
            if (alu_op == 3'd4) o.mulcyc++;
            if (illegal_instr) begin
                o.ill_cyc = cyc;
                fin = 1'b1;
            end
            if (instr_done) begin
                o.lat = cyc; o.alu = alu_op; o.dst = reg_dst; o.m2r = mem_to_reg;
                o.pcw = pc_write; o.rdy = mem_ready;
                if (pc_write != pc_src) o.pcw = 1'bx;
                fin = 1'b1;
            end
        end
        @(posedge clk);
        @(negedge clk);
        mem_ready = 1'b0;
        #1;
        o.cnt = instr_count;
        check({tag, ".idle"}, {31'd0, busy}, 32'd0);
        e = r_sb.pop_front();
        check({tag, ".latency"},  o.lat,     e.lat);
        check({tag, ".illegal"},  o.ill_cyc, e.ill_cyc);
        check({tag, ".reg_write"}, {31'd0, o.regw}, {31'd0, e.regw});
        check({tag, ".mem_cycles"}, o.memcyc, e.memcyc);
        check({tag, ".mul_cycles"}, o.mulcyc, e.mulcyc);
        check({tag, ".ctl"}, {27'd0, o.alu, o.dst, o.m2r},
                             {27'd0, e.alu, e.dst, e.m2r});
        check({tag, ".pc_rdy"}, {30'd0, o.pcw, o.rdy}, {30'd0, e.pcw, e.rdy});
        check({tag, ".count"}, {16'd0, o.cnt}, {16'd0, e.cnt});
    endtask

    initial begin
        int lat;
        // Reset and its idle state
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        check("reset.outs", {18'd0, w_outs}, 32'd0);
        check("reset.busy_cnt", {15'd0, busy, instr_count}, 32'd0);
        rst_n = 1'b1;
        r_model_cnt = 16'd0;

        exec_instr(32'h04644820, 0, 1'b0, "add");
        exec_instr(32'h04644822, 0, 1'b0, "sub");
        exec_instr(32'h04644824, 0, 1'b0, "and");
        exec_instr(32'h04644825, 0, 1'b0, "or");
        exec_instr(32'h04224032, 0, 1'b0, "mul4");
        exec_instr(32'h0CCA0000, 3, 1'b0, "sw_w3");
        exec_instr(32'h0CCA0000, 0, 1'b0, "sw_w0");
        exec_instr(32'h08CA0000, 0, 1'b0, "lw_w0");
        exec_instr(32'h08CA0000, 2, 1'b0, "lw_w2");
        exec_instr(32'h10220000, 0, 1'b1, "beq_taken");
        exec_instr(32'h10220000, 0, 1'b0, "beq_not");
        exec_instr(32'hFC000000, 0, 1'b0, "ill_op");
        exec_instr(32'h04644800, 0, 1'b0, "ill_fn");

        // Stall: no valid word keeps FETCH quiet
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            check("stall.outs", {18'd0, w_outs}, 32'd0);
            check("stall.busy", {31'd0, busy}, 32'd0);
        end
        check("stall.count", {16'd0, instr_count}, {16'd0, r_model_cnt});

        // MUL_CYCLES = 1 instance
        @(negedge clk);
        instruction_memory = 32'h04224032;
        instr_valid1 = 1'b1;
        lat = 0;
        for (int c = 1; c < 20 && lat == 0; c++) begin
            #1;
            if (d1_instr_done) lat = c;
            @(posedge clk);
            @(negedge clk);
            instr_valid1 = 1'b0;
        end
        check("mul1.latency", lat, 4);

        // Reset in the second MULW cycle
        @(negedge clk);
        instruction_memory = 32'h04224032;
        instr_valid = 1'b1;
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
            instr_valid = 1'b0;
        end
        #1;
        check("mrst.in_mulw", {29'd0, alu_op}, 32'd4);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        r_model_cnt = 16'd0;
        check("mrst.outs", {18'd0, w_outs}, 32'd0);
        check("mrst.busy_cnt", {15'd0, busy, instr_count}, 32'd0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            #1;
            check("mrst.no_done", {31'd0, instr_done}, 32'd0);
        end

        // Counter wrap
        @(negedge clk);
        force dut.r_instr_count = 16'hFFFF;
        @(negedge clk);
        release dut.r_instr_count;
        r_model_cnt = 16'hFFFF;
        exec_instr(32'h04644820, 0, 1'b0, "wrap");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/multicycle_sequencer.md
Name: multicycle_sequencer

Overview:
- Multi-cycle main controller for the MIPS-style datapath: latches each instruction word, decodes opcode/funct and steps the datapath through fetch, decode, execute, memory and writeback.
- Replaces the single-cycle control word for multicycle operation and adds a variable-latency multiply and a memory handshake.
- Sits between instruction memory and the register file / ALU / data memory enables.

Parameters:
- MUL_CYCLES, 4, number of cycles spent in MULW for mul (legal range 1..15).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  synchronous active-low reset, sampled on the rising edge of clk.
- instruction_memory  in  32  instruction word from instruction memory.
- instr_valid  in  1  instruction_memory holds a valid word this cycle.
- mem_ready  in  1  data memory has completed the current access.
- alu_zero  in  1  ALU zero flag, used in BRANCH.
- pc_write  out  1  PC load enable.
- pc_src  out  1  0 = PC+4, 1 = branch target.
- ir_write  out  1  instruction register load enable.
- reg_write  out  1  register file write enable.
- reg_dst  out  1  1 = rd, 0 = rt.
- mem_to_reg  out  1  1 = write memory data, 0 = write ALU result.
- alu_src  out  1  1 = sign-extended immediate, 0 = rt.
- alu_op  out  3  000 add, 001 sub, 010 and, 011 or, 100 mul.
- mem_read  out  1  data memory read strobe.
- mem_write  out  1  data memory write strobe.
- instr_done  out  1  one-cycle retire pulse.
- illegal_instr  out  1  one-cycle pulse on an undecodable instruction.
- busy  out  1  high in every state except FETCH.
- instr_count  out  16  retired-instruction counter; wraps at 0xFFFF.

Behaviour:
- Decode. opcode = [31:26], funct = [5:0].
  - 000001 is R-type. Funct 100000 add, 100010 sub, 100100 and, 100101 or, 110010 mul.
  - 000010 is lw, 000011 is sw, 000100 is beq.
  - Any other opcode, or an unknown funct under 000001, is illegal.
- Internal state: 32-bit IR, 4-bit state register, 4-bit multiply counter.
- Reset: when rst_n = 0 at a clock edge, state goes to FETCH and IR, multiply counter and instr_count go to 0. This applies mid-instruction too: no retire, and no memory strobe in the cycle after the reset edge.
- Output defaults: every output is 0 unless a state below drives it. The only exceptions are busy and instr_count.
- FETCH:
  - If instr_valid = 1: ir_write = 1, pc_write = 1, pc_src = 0; IR captures instruction_memory; go to DECODE.
  - If instr_valid = 0: hold in FETCH with no strobes.
- DECODE (one cycle, no strobes):
  - add/sub/and/or go to EXEC.
  - mul loads the counter with MUL_CYCLES-1 and goes to MULW.
  - lw/sw go to ADDR.
  - beq goes to BRANCH.
  - Illegal: illegal_instr = 1 for this cycle, go to FETCH, no retire, instr_count unchanged.
- EXEC: alu_op per funct, alu_src = 0; go to WB.
- MULW:
  - alu_op = 100 for the whole dwell.
  - Counter decrements each cycle; when counter = 0, go to WB.
  - Dwell is exactly MUL_CYCLES cycles.
- ADDR: alu_op = 000, alu_src = 1; go to MEM.
- MEM:
  - alu_op = 000, alu_src = 1 held. mem_read = 1 (lw) or mem_write = 1 (sw), held until the cycle in which mem_ready = 1 inclusive.
  - When mem_ready = 1: lw goes to WB; sw asserts instr_done combinationally in that cycle and goes to FETCH.
  - mem_ready while not in MEM is ignored.
- WB: reg_write = 1, instr_done = 1; go to FETCH.
  - R-type: reg_dst = 1, mem_to_reg = 0. ALU op as in EXEC, or 100 for mul.
  - lw: reg_dst = 0, mem_to_reg = 1.
- BRANCH: alu_op = 001, alu_src = 0, instr_done = 1; go to FETCH.
  - If alu_zero = 1: pc_write = 1, pc_src = 1.
  - If alu_zero = 0: pc_write = 0.
- instr_count increments on the clock edge ending every cycle with instr_done = 1.
- Latency, from FETCH acceptance to instr_done (inclusive):
  - add/sub/and/or: 4 cycles.
  - mul: 3 + MUL_CYCLES cycles.
  - sw: 4 + W cycles.
  - lw: 5 + W cycles.
  - beq: 3 cycles.
  - W = number of MEM cycles with mem_ready = 0.
- Unreachable state encodings go to FETCH on the next edge.

Test Plan:
- Reset then add: rst_n low for 2 cycles, then instruction 000001_00011_00100_01001_00000_100000 with instr_valid = 1.
  - Required: pass through FETCH, DECODE, EXEC, WB; alu_op = 000 in EXEC/WB; reg_write = 1 and reg_dst = 1 in WB; instr_done in cycle 4; instr_count = 1.
- mul with MUL_CYCLES = 4: instruction 000001_00001_00010_01000_00000_110010.
  - Required: alu_op = 100 for 4 MULW cycles then WB; instr_done in cycle 7.
  - Repeat with MUL_CYCLES = 1: instr_done in cycle 4.
- sw with wait states: instruction 000011_00110_01010_0000000000000000, mem_ready held low for 3 MEM cycles.
  - Required: mem_write = 1 for 4 cycles; instr_done coincident with mem_ready = 1; reg_write never asserted.
- lw and beq: lw with mem_ready = 1 immediately gives instr_done in cycle 5 with mem_to_reg = 1, reg_dst = 0.
  - beq with alu_zero = 1: pc_write = 1, pc_src = 1 in cycle 3.
  - beq with alu_zero = 0: pc_write = 0.
- Illegal and stall: opcode 111111, then R-type with funct 000000.
  - Required: each gives illegal_instr for one cycle in DECODE, no instr_done, instr_count unchanged.
  - instr_valid = 0 for 5 cycles holds FETCH with all strobes 0 and busy = 0.
- Reset mid-operation: assert rst_n = 0 during the second MULW cycle.
  - Required: after the edge state = FETCH, all outputs 0, instr_count = 0, no instr_done.
  - Also check instr_count wraps 0xFFFF to 0x0000 (preload by running 65536 adds, or force).
